// File: rtl/clct_deadtime_sel.sv
// -----------------------------------------------------------------------------
// clct_deadtime_sel
//
// Picks the first and second CLCT out of the best-1-of-5 sorter stream.
// An eligible sorter output seen while idle becomes clct0 and opens a
// dead-time window of drift_delay clocks. During that window the key group
// of clct0 (and a neighbour group when the key sits near a group edge) is
// reported busy on bsy_grp. The best eligible non-busy input seen during
// the window becomes clct1 and is emitted when the window closes.
//
// Ports
//   clock        : sole clock, all state changes on the rising edge
//   reset        : asynchronous, active-high, clears all state
//   best_pat     : sorter pattern; [5:3] = layer hits, [5:1] = sort key
//   best_key     : sorter key half-strip; [7:5] = group, [4:0] = position
//   best_carry   : sorter side-band data carried along with the CLCT
//   best_bsy     : sorter output is not valid this clock
//   hit_thresh   : minimum layer-hit count for acceptance
//   drift_delay  : dead-time length in clocks, 0 = no dead time
//   clct0_*      : first CLCT (vld pulses one clock, data held)
//   clct1_*      : second CLCT (vld pulses one clock, data held)
//   bsy_grp      : per-32-half-strip key-group busy mask for the sorter
//   hold_active  : dead-time window open
//   key_err      : sticky flag, a non-busy input carried key group 7
// -----------------------------------------------------------------------------
module clct_deadtime_sel (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  best_pat,
  input  logic [7:0]  best_key,
  input  logic [11:0] best_carry,
  input  logic        best_bsy,
  input  logic [2:0]  hit_thresh,
  input  logic [3:0]  drift_delay,
  output logic        clct0_vld,
  output logic [5:0]  clct0_pat,
  output logic [7:0]  clct0_key,
  output logic [11:0] clct0_carry,
  output logic        clct1_vld,
  output logic [5:0]  clct1_pat,
  output logic [7:0]  clct1_key,
  output logic [11:0] clct1_carry,
  output logic [6:0]  bsy_grp,
  output logic        hold_active,
  output logic        key_err
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;

  // Best secondary candidate collected so far in the current window
  logic        sec_held_reg;
  logic [5:0]  sec_pat_reg;
  logic [7:0]  sec_key_reg;
  logic [11:0] sec_carry_reg;

  // Input decode
  logic [2:0]  hits;
  logic [2:0]  grp;
  logic [4:0]  pos;
  logic        eligible;
  logic        bad_key;
  logic [6:0]  new_mask;
  logic [7:0]  busy_ext;
  logic        grp_busy;

  assign hits     = best_pat[5:3];
  assign grp      = best_key[7:5];
  assign pos      = best_key[4:0];
  assign bad_key  = !best_bsy && (grp == 3'd7);
  assign eligible = !best_bsy && (hits >= hit_thresh) && (grp != 3'd7);

  // Group 7 does not exist in the mask; padding keeps the lookup in range.
  assign busy_ext = {1'b0, bsy_grp};
  assign grp_busy = busy_ext[grp];

  // Busy mask for a new clct0: its own group, plus the lower neighbour when
  // the key is within 4 half-strips of the low edge, plus the upper
  // neighbour when within 4 half-strips of the high edge.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_mask
      logic own_hit;
      logic from_upper;
      logic from_lower;
      assign own_hit = (grp == 3'(gi));
      if (gi < 6) begin : g_upper
        assign from_upper = (grp == 3'(gi + 1)) && (pos < 5'd4);
      end else begin : g_no_upper
        assign from_upper = 1'b0;
      end
      if (gi > 0) begin : g_lower
        assign from_lower = (grp == 3'(gi - 1)) && (pos > 5'd27);
      end else begin : g_no_lower
        assign from_lower = 1'b0;
      end
      assign new_mask[gi] = own_hit | from_upper | from_lower;
    end
  endgenerate

  // Secondary selection: a strictly larger sort key wins, ties keep the
  // earlier candidate. The candidate arriving on the closing edge still
  // takes part in the selection.
  logic        take_sec;
  logic        merged_held;
  logic [5:0]  merged_pat;
  logic [7:0]  merged_key;
  logic [11:0] merged_carry;

  assign take_sec = (state_reg == HOLD) && eligible && !grp_busy &&
                    (!sec_held_reg || (best_pat[5:1] > sec_pat_reg[5:1]));

  assign merged_held  = sec_held_reg | take_sec;
  assign merged_pat   = take_sec ? best_pat   : sec_pat_reg;
  assign merged_key   = take_sec ? best_key   : sec_key_reg;
  assign merged_carry = take_sec ? best_carry : sec_carry_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      sec_held_reg  <= 1'b0;
      sec_pat_reg   <= 6'd0;
      sec_key_reg   <= 8'd0;
      sec_carry_reg <= 12'd0;
      clct0_vld     <= 1'b0;
      clct0_pat     <= 6'd0;
      clct0_key     <= 8'd0;
      clct0_carry   <= 12'd0;
      clct1_vld     <= 1'b0;
      clct1_pat     <= 6'd0;
      clct1_key     <= 8'd0;
      clct1_carry   <= 12'd0;
      bsy_grp       <= 7'd0;
      hold_active   <= 1'b0;
      key_err       <= 1'b0;
    end else begin
      clct0_vld <= 1'b0;
      clct1_vld <= 1'b0;

      if (bad_key) begin
        key_err <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (eligible) begin
            clct0_vld   <= 1'b1;
            clct0_pat   <= best_pat;
            clct0_key   <= best_key;
            clct0_carry <= best_carry;
            // drift_delay is only looked at here; later changes do not
            // stretch or shorten an open window.
            if (drift_delay != 4'd0) begin
              state_reg   <= HOLD;
              cnt_reg     <= drift_delay;
              bsy_grp     <= new_mask;
              hold_active <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (cnt_reg == 4'd1) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            bsy_grp      <= 7'd0;
            hold_active  <= 1'b0;
            sec_held_reg <= 1'b0;
            if (merged_held) begin
              clct1_vld   <= 1'b1;
              clct1_pat   <= merged_pat;
              clct1_key   <= merged_key;
              clct1_carry <= merged_carry;
            end
          end else begin
            cnt_reg       <= cnt_reg - 4'd1;
            sec_held_reg  <= merged_held;
            sec_pat_reg   <= merged_pat;
            sec_key_reg   <= merged_key;
            sec_carry_reg <= merged_carry;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clct_deadtime_sel.sv
// -----------------------------------------------------------------------------
// tb_clct_deadtime_sel
//
// Scoreboard bench. Directed scenarios followed by random traffic. A
// behavioural model runs on each rising edge and queues the expected
// per-cycle status and the expected clct0/clct1 records; a monitor on the
// falling edge pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_clct_deadtime_sel;

  logic        clock;
  logic        reset;
  logic [5:0]  best_pat;
  logic [7:0]  best_key;
  logic [11:0] best_carry;
  logic        best_bsy;
  logic [2:0]  hit_thresh;
  logic [3:0]  drift_delay;
  logic        clct0_vld;
  logic [5:0]  clct0_pat;
  logic [7:0]  clct0_key;
  logic [11:0] clct0_carry;
  logic        clct1_vld;
  logic [5:0]  clct1_pat;
  logic [7:0]  clct1_key;
  logic [11:0] clct1_carry;
  logic [6:0]  bsy_grp;
  logic        hold_active;
  logic        key_err;
  logic        fin;

  clct_deadtime_sel dut (
    .clock       (clock),
    .reset       (reset),
    .best_pat    (best_pat),
    .best_key    (best_key),
    .best_carry  (best_carry),
    .best_bsy    (best_bsy),
    .hit_thresh  (hit_thresh),
    .drift_delay (drift_delay),
    .clct0_vld   (clct0_vld),
    .clct0_pat   (clct0_pat),
    .clct0_key   (clct0_key),
    .clct0_carry (clct0_carry),
    .clct1_vld   (clct1_vld),
    .clct1_pat   (clct1_pat),
    .clct1_key   (clct1_key),
    .clct1_carry (clct1_carry),
    .bsy_grp     (bsy_grp),
    .hold_active (hold_active),
    .key_err     (key_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  pat;
    logic [7:0]  key;
    logic [11:0] carry;
  } rec_t;

  typedef struct {
    logic [6:0] bsy;
    logic       hold;
    logic       err;
    logic       v0;
    logic       v1;
  } st_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t cands[$];
  st_t  qs[$];

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  // Model state: remaining dead-time clocks, the busy mask, the sticky error
  int         m_left = 0;
  logic [7:0] m_mask = 8'd0;
  logic       m_err  = 1'b0;

  task automatic model_clear();
    m_left = 0;
    m_mask = 8'd0;
    m_err  = 1'b0;
    cands.delete();
    q0.delete();
    q1.delete();
    qs.delete();
  endtask

  task automatic model_step();
    logic [2:0] g;
    logic [4:0] p;
    bit         elig;
    st_t        s;
    rec_t       r;
    rec_t       best;
    g = best_key[7:5];
    p = best_key[4:0];
    r.pat   = best_pat;
    r.key   = best_key;
    r.carry = best_carry;
    if (!best_bsy && g == 3'd7) m_err = 1'b1;
    elig = !best_bsy && (best_pat[5:3] >= hit_thresh) && (g != 3'd7);
    s.v0 = 1'b0;
    s.v1 = 1'b0;
    if (m_left > 0) begin
      if (elig && !m_mask[g]) cands.push_back(r);
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (cands.size() > 0) begin
          best = cands[0];
          foreach (cands[i])
            if (cands[i].pat[5:1] > best.pat[5:1]) best = cands[i];
          q1.push_back(best);
          s.v1 = 1'b1;
        end
        cands.delete();
        m_mask = 8'd0;
      end
    end else if (elig) begin
      q0.push_back(r);
      s.v0 = 1'b1;
      if (drift_delay != 4'd0) begin
        m_left = int'(drift_delay);
        m_mask = 8'(1 << g);
        if (p < 5'd4 && g > 3'd0)  m_mask = m_mask | 8'(1 << (g - 3'd1));
        if (p > 5'd27 && g < 3'd6) m_mask = m_mask | 8'(1 << (g + 3'd1));
      end
    end
    s.bsy  = (m_left > 0) ? m_mask[6:0] : 7'd0;
    s.hold = (m_left > 0);
    s.err  = m_err;
    qs.push_back(s);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_clear();
    else       model_step();
  end

  // Monitor: all comparisons live here
  always begin
    st_t  s;
    rec_t r;
    @(negedge clock or posedge reset or posedge fin);
    if (fin) begin
      total++;
      if (q0.size() != 0 || q1.size() != 0 || qs.size() != 0) begin
        bad++;
        $display("FAIL leftover q0=%0d q1=%0d qs=%0d required all 0",
                 q0.size(), q1.size(), qs.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (reset) begin
      #1;
      if (reset) begin
        total++;
        if ({clct0_vld, clct0_pat, clct0_key, clct0_carry, clct1_vld, clct1_pat,
             clct1_key, clct1_carry, bsy_grp, hold_active, key_err} !== 63'd0) begin
          bad++;
          $display("FAIL reset_outputs t=%0t bsy=%h hold=%b err=%b v0=%b v1=%b required all 0",
                   $time, bsy_grp, hold_active, key_err, clct0_vld, clct1_vld);
        end
      end
    end else begin
      cyc++;
      total++;
      if (qs.size() == 0) begin
        bad++;
        $display("FAIL status_missing cyc=%0d no expected record", cyc);
      end else begin
        s = qs.pop_front();
        if ({bsy_grp, hold_active, key_err, clct0_vld, clct1_vld} !==
            {s.bsy, s.hold, s.err, s.v0, s.v1}) begin
          bad++;
          $display("FAIL status cyc=%0d got bsy=%b hold=%b err=%b v0=%b v1=%b required bsy=%b hold=%b err=%b v0=%b v1=%b",
                   cyc, bsy_grp, hold_active, key_err, clct0_vld, clct1_vld,
                   s.bsy, s.hold, s.err, s.v0, s.v1);
        end
      end
      if (clct0_vld) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL clct0_unexpected cyc=%0d key=%0d", cyc, clct0_key);
        end else begin
          r = q0.pop_front();
          if ({clct0_pat, clct0_key, clct0_carry} !== {r.pat, r.key, r.carry}) begin
            bad++;
            $display("FAIL clct0_data cyc=%0d got pat=%b key=%0d carry=%h required pat=%b key=%0d carry=%h",
                     cyc, clct0_pat, clct0_key, clct0_carry, r.pat, r.key, r.carry);
          end else begin
            $display("clct0 cyc=%0d pat=%b key=%0d carry=%h ok", cyc, clct0_pat, clct0_key, clct0_carry);
          end
        end
      end
      if (clct1_vld) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL clct1_unexpected cyc=%0d key=%0d", cyc, clct1_key);
        end else begin
          r = q1.pop_front();
          if ({clct1_pat, clct1_key, clct1_carry} !== {r.pat, r.key, r.carry}) begin
            bad++;
            $display("FAIL clct1_data cyc=%0d got pat=%b key=%0d carry=%h required pat=%b key=%0d carry=%h",
                     cyc, clct1_pat, clct1_key, clct1_carry, r.pat, r.key, r.carry);
          end else begin
            $display("clct1 cyc=%0d pat=%b key=%0d carry=%h ok", cyc, clct1_pat, clct1_key, clct1_carry);
          end
        end
      end
    end
  end

  // Stimulus: called at a falling edge, holds the input for one clock
  task automatic drive(input logic [5:0] p, input logic [7:0] k,
                       input logic [11:0] c, input logic b);
    best_pat   = p;
    best_key   = k;
    best_carry = c;
    best_bsy   = b;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(6'd0, 8'd0, 12'd0, 1'b1);
  endtask

  // Reset pulse placed between a falling edge and the next rising edge
  task automatic do_reset();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
  endtask

  initial begin
    fin         = 1'b0;
    reset       = 1'b0;
    hit_thresh  = 3'd3;
    drift_delay = 4'd0;
    // Eligible from time zero: captured on the first edge after reset
    best_pat    = 6'b111000;
    best_key    = 8'd10;
    best_carry  = 12'h5a5;
    best_bsy    = 1'b0;
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clock);

    // Basic capture with a 4-clock window, group 2 only
    drift_delay = 4'd4;
    drive(6'b101010, 8'd70, 12'h123, 1'b0);
    idle(6);

    // Neighbour groups: low edge of group 1, high edge of group 6
    drift_delay = 4'd2;
    drive(6'b111000, 8'd33, 12'h001, 1'b0);
    idle(3);
    drive(6'b111000, 8'd223, 12'h002, 1'b0);
    idle(3);

    // Secondary selection during a 3-clock window
    drift_delay = 4'd3;
    drive(6'b111000, 8'd40, 12'h0a0, 1'b0);
    drive(6'b100101, 8'd150, 12'h0b0, 1'b0);
    drive(6'b110011, 8'd160, 12'h0c0, 1'b0);
    drive(6'b111111, 8'd45, 12'h0d0, 1'b0);
    idle(3);

    // No dead time: back-to-back captures
    drift_delay = 4'd0;
    drive(6'b111000, 8'd12, 12'h111, 1'b0);
    drive(6'b110000, 8'd99, 12'h222, 1'b0);
    idle(2);

    // Below hit threshold
    drive(6'b010111, 8'd20, 12'h333, 1'b0);
    idle(2);

    // Reset in a window with a secondary held
    drift_delay = 4'd5;
    drive(6'b111000, 8'd100, 12'h444, 1'b0);
    drive(6'b110000, 8'd10, 12'h555, 1'b0);
    do_reset();
    idle(8);

    // Illegal group, sticky error
    drive(6'b111000, 8'd230, 12'h666, 1'b0);
    idle(3);
    drift_delay = 4'd2;
    drive(6'b111000, 8'd5, 12'h777, 1'b0);
    idle(3);
    do_reset();
    idle(2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] k;
      if ($urandom_range(0, 99) == 0) begin
        hit_thresh  = 3'($urandom_range(0, 7));
        drift_delay = 4'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      k = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(224, 255))
                                       : 8'($urandom_range(0, 223));
      drive(6'($urandom_range(0, 63)), k, 12'($urandom_range(0, 4095)),
            ($urandom_range(0, 3) == 0));
    end
    idle(20);
    #1 fin = 1'b1;
  end

endmodule

// File: doc/clct_deadtime_sel.md
CLCT_DEADTIME_SEL -- requirements
Module: clct_deadtime_sel

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports best_pat input 6, best_key input 8, best_carry input 12, best_bsy input 1: combinational output of the upstream best-1-of-5 sorter, sampled every clock.
REQ-004 SHALL have port hit_thresh, input, 3, minimum layer-hit count for acceptance.
REQ-005 SHALL have port drift_delay, input, 4, dead-time length in clocks (0..15).
REQ-006 SHALL have ports clct0_vld output 1, clct0_pat output 6, clct0_key output 8, clct0_carry output 12: first-CLCT registered result.
REQ-007 SHALL have ports clct1_vld output 1, clct1_pat output 6, clct1_key output 8, clct1_carry output 12: second-CLCT registered result.
REQ-008 SHALL have port bsy_grp, output, 7, per-32-half-strip key-group busy mask fed back to the sorter busy inputs.
REQ-009 SHALL have ports hold_active output 1 (dead-time window open) and key_err output 1 (sticky illegal-group flag).

Function
REQ-010 Field decode SHALL be: hits = pat[5:3], sort key = pat[5:1], group g = key[7:5], in-group position p = key[4:0].
REQ-011 An input SHALL be eligible when best_bsy=0, hits >= hit_thresh, and g <= 6.
REQ-012 Any sampled input with best_bsy=0 and g=7 SHALL set key_err and be discarded; key_err clears only on reset.
REQ-013 FSM SHALL have two states: IDLE and HOLD, plus a 4-bit down-counter cnt.
REQ-014 IDLE, eligible input at edge k: SHALL latch pat/key/carry into clct0 registers; clct0_vld=1 during cycle k+1 only; clct0 data held until the next clct0 capture.
REQ-015 At the same edge k, if drift_delay>0: SHALL go to HOLD, load cnt=drift_delay, load busy mask; if drift_delay=0: SHALL stay in IDLE with no busy mask.
REQ-016 Busy mask SHALL set bit g; also bit g-1 if p<4 and g>0; also bit g+1 if p>27 and g<6.
REQ-017 bsy_grp SHALL equal the latched mask during every HOLD cycle and 0 in IDLE; hold_active=1 exactly in HOLD.
REQ-018 HOLD SHALL last exactly drift_delay cycles (k+1 .. k+D): cnt decrements each edge; edge with cnt=1 returns to IDLE and clears the mask.
REQ-019 In HOLD, an eligible input whose group bit is clear in bsy_grp SHALL be a secondary candidate; it replaces the held secondary only if none is held or its sort key is strictly greater (ties keep earlier).
REQ-020 Inputs in HOLD with their group busy SHALL be ignored; no clct0 capture occurs in HOLD.
REQ-021 If a secondary is held at the HOLD->IDLE edge: SHALL copy it to clct1 registers, clct1_vld=1 during cycle k+D+1 only, clear the secondary-held flag.
REQ-022 In cycle k+D+1 (IDLE), a new eligible input SHALL be accepted per REQ-014 regardless of clct1_vld; both vld pulses may then occur in adjacent cycles.
REQ-023 drift_delay and hit_thresh SHALL be sampled when used: drift_delay only at clct0 capture; changes mid-HOLD do not alter cnt.
REQ-024 Latency input->clct0_vld SHALL be 1 clock; all outputs registered, no combinational path from inputs to outputs.

Reset
REQ-025 On reset SHALL force: state IDLE, cnt=0, all vld=0, all pat/key/carry outputs=0, bsy_grp=0, hold_active=0, key_err=0, secondary-held flag=0.
REQ-026 Reset asserted mid-HOLD SHALL drop bsy_grp and hold_active asynchronously; a held secondary is discarded and never emitted.
REQ-027 First capture SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-028 hit_thresh=3, drift_delay=4, pat=6'b101010, key=8'd70 for one clock at edge k -> clct0_vld at k+1 only, clct0_key=70, bsy_grp=7'b0000100 cycles k+1..k+4, hold_active same window, 0 at k+5.
REQ-029 drift_delay=2, key=8'd33 (g=1,p=1) -> bsy_grp=7'b0000011; key=8'd223 (g=6,p=31) -> bsy_grp=7'b1000000.
REQ-030 drift_delay=3, capture key=40; during HOLD present key=150 pat=6'b100xxx then key=160 pat=6'b110xxx then key=45 pat=6'b111xxx -> clct1_vld one cycle after HOLD, clct1_key=160 (key 45 busy-ignored).
REQ-031 drift_delay=0, eligible input on two consecutive edges -> two consecutive clct0_vld pulses, bsy_grp stays 0, clct1_vld never set.
REQ-032 best_bsy=0, key=8'd230 -> key_err=1 sticky, no vld; pat hits=2 with hit_thresh=3 -> ignored; reset asserted during HOLD with secondary held -> all outputs 0 immediately, no clct1_vld after release.
